// File: rtl/arb_pkg.sv
// Shared types for the IF/LS memory port arbiter.
package arb_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_e;
   typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} own_e;
   localparam int ARB_TIMEOUT = 256;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester that did not win last time gets it.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);
   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
   end
endmodule

// File: rtl/mem_arb.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and load/store,
// with round-robin fairness and a response timeout that returns an error to the owner.
module mem_arb
   import arb_pkg::*;
#(
   parameter int AW      = 64,
   parameter int DW      = 64,
   parameter int TIMEOUT = ARB_TIMEOUT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            if_req_valid_i,
   output logic            if_req_ready_o,
   input  logic [AW-1:0]   if_addr_i,
   output logic            if_rsp_valid_o,
   output logic [DW-1:0]   if_rsp_data_o,
   output logic            if_rsp_err_o,
   input  logic            ls_req_valid_i,
   output logic            ls_req_ready_o,
   input  logic [AW-1:0]   ls_addr_i,
   input  logic            ls_wen_i,
   input  logic [DW-1:0]   ls_wdata_i,
   input  logic [DW/8-1:0] ls_wmask_i,
   output logic            ls_rsp_valid_o,
   output logic [DW-1:0]   ls_rsp_data_o,
   output logic            ls_rsp_err_o,
   output logic            mem_req_valid_o,
   input  logic            mem_req_ready_i,
   output logic [AW-1:0]   mem_addr_o,
   output logic            mem_wen_o,
   output logic [DW-1:0]   mem_wdata_o,
   output logic [DW/8-1:0] mem_wmask_o,
   input  logic            mem_rsp_valid_i,
   input  logic [DW-1:0]   mem_rsp_data_i,
   input  logic            mem_rsp_err_i
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic            wen;
      logic [DW-1:0]   wdata;
      logic [DW/8-1:0] wmask;
   } mreq_t;

   arb_state_e    state_q;
   own_e          owner_q, last_q;
   logic          stale_q;
   logic [CW-1:0] cnt_q;
   mreq_t         req_q;
   logic          mem_vld_q;

   logic [1:0]    gnt;
   logic          idle_en, rsp_fwd, tmo, rsp_vld, rsp_err;
   logic [DW-1:0] rsp_data;

   rr_arb2 u_rr (
      .req  ({ls_req_valid_i, if_req_valid_i}),
      .last (last_q),
      .gnt  (gnt)
   );

   // Ready is gated by reset too, so a held request sees no acceptance while reset is low.
   assign idle_en        = rst_i && (state_q == IDLE);
   assign if_req_ready_o = idle_en && gnt[0];
   assign ls_req_ready_o = idle_en && gnt[1];

   assign rsp_fwd  = (state_q == WAIT) && mem_rsp_valid_i && !stale_q;
   assign tmo      = (TIMEOUT != 0) && (state_q == WAIT) && !rsp_fwd && (cnt_q == CW'(TIMEOUT - 1));
   assign rsp_vld  = rsp_fwd || tmo;
   assign rsp_data = rsp_fwd ? mem_rsp_data_i : '0;
   assign rsp_err  = rsp_fwd ? mem_rsp_err_i : tmo;

   assign if_rsp_valid_o = rsp_vld && (owner_q == OWN_IF);
   assign if_rsp_data_o  = (owner_q == OWN_IF) ? rsp_data : '0;
   assign if_rsp_err_o   = rsp_err && (owner_q == OWN_IF);
   assign ls_rsp_valid_o = rsp_vld && (owner_q == OWN_LS);
   assign ls_rsp_data_o  = (owner_q == OWN_LS) ? rsp_data : '0;
   assign ls_rsp_err_o   = rsp_err && (owner_q == OWN_LS);

   assign mem_req_valid_o = mem_vld_q;
   assign mem_addr_o      = req_q.addr;
   assign mem_wen_o       = req_q.wen;
   assign mem_wdata_o     = req_q.wdata;
   assign mem_wmask_o     = req_q.wmask;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         owner_q   <= OWN_IF;
         last_q    <= OWN_LS;
         stale_q   <= 1'b0;
         cnt_q     <= '0;
         req_q     <= '0;
         mem_vld_q <= 1'b0;
      end else begin
         // The first response after a timeout belongs to the abandoned request; drop it.
         if (mem_rsp_valid_i && stale_q) stale_q <= 1'b0;
         case (state_q)
            IDLE: if (|gnt) begin
               owner_q     <= gnt[1] ? OWN_LS : OWN_IF;
               last_q      <= gnt[1] ? OWN_LS : OWN_IF;
               req_q.addr  <= gnt[1] ? ls_addr_i : if_addr_i;
               req_q.wen   <= gnt[1] && ls_wen_i;
               req_q.wdata <= gnt[1] ? ls_wdata_i : '0;
               req_q.wmask <= gnt[1] ? ls_wmask_i : '0;
               mem_vld_q   <= 1'b1;
               state_q     <= REQ;
            end
            REQ: if (mem_req_ready_i) begin
               mem_vld_q <= 1'b0;
               cnt_q     <= '0;
               state_q   <= WAIT;
            end
            WAIT: begin
               if (rsp_fwd) begin
                  state_q <= IDLE;
               end else begin
                  if (cnt_q != {CW{1'b1}}) cnt_q <= cnt_q + 1'b1;
                  if (tmo) begin
                     stale_q <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   a_rsp_proto: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(mem_rsp_valid_i && !stale_q && (state_q != WAIT)))
      else $warning("mem_arb: memory response with no transaction outstanding, ignored");
endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates one shared memory port between instruction fetch (IF) and load/store (LS) for the multi-cycle core.
- Accepts one request at a time, registers it, and drives the memory request channel.
- Routes the response back to the requester that owns the transaction.
- Provides round-robin fairness and a response timeout that reports an error instead of hanging the core.

Parameters:
- AW, 64, address width.
- DW, 64, data width (byte mask width is DW/8).
- TIMEOUT, 256, cycles allowed in WAIT before an error response; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- if_req_valid_i  in  1  IF request valid.
- if_req_ready_o  out  1  IF request accepted this cycle.
- if_addr_i  in  AW  IF address.
- if_rsp_valid_o  out  1  IF response valid (one-cycle pulse).
- if_rsp_data_o  out  DW  IF response data.
- if_rsp_err_o  out  1  IF response error.
- ls_req_valid_i  in  1  LS request valid.
- ls_req_ready_o  out  1  LS request accepted this cycle.
- ls_addr_i  in  AW  LS address.
- ls_wen_i  in  1  1 = store, 0 = load.
- ls_wdata_i  in  DW  store data.
- ls_wmask_i  in  DW/8  store byte mask.
- ls_rsp_valid_o  out  1  LS response valid (one-cycle pulse).
- ls_rsp_data_o  out  DW  LS response data.
- ls_rsp_err_o  out  1  LS response error.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory request accepted.
- mem_addr_o  out  AW  memory address.
- mem_wen_o  out  1  memory write enable.
- mem_wdata_o  out  DW  memory write data.
- mem_wmask_o  out  DW/8  memory write byte mask.
- mem_rsp_valid_i  in  1  memory response valid.
- mem_rsp_data_i  in  DW  memory response data.
- mem_rsp_err_i  in  1  memory response error.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, owner=IF, last_grant=LS (so IF wins first after reset), stale=0, timeout counter=0.
  - All *_valid_o, *_ready_o, mem_wen_o = 0; all data, address and mask registers = 0.
  - Reset asserted mid-transaction abandons it; no response is generated.
- States: IDLE, REQ, WAIT.
- IDLE:
  - Arbitrate. A single valid requester is granted.
  - If both are valid, grant the one that is not last_grant.
  - The granted *_req_ready_o=1 combinationally in the same cycle.
  - Register address, wen, wdata and wmask; IF requests force wen=0 and mask=0.
  - Set owner and last_grant to the granted requester; go to REQ.
  - The non-granted requester keeps ready=0 and must hold its request stable.
- REQ:
  - mem_req_valid_o=1, driven from the registered fields, which stay stable until handshake.
  - On mem_req_ready_i=1, go to WAIT and clear the counter. No timeout in REQ.
- WAIT:
  - When mem_rsp_valid_i=1 and stale=0: forward combinationally to the owner as {rsp_valid, data, err} = {1, mem_rsp_data_i, mem_rsp_err_i}, then go to IDLE.
  - Otherwise increment the counter. If TIMEOUT≠0 and counter==TIMEOUT-1 with no response: owner rsp_valid=1, err=1, data=0; set stale=1; go to IDLE.
- Stale responses:
  - The first mem_rsp_valid_i seen while stale=1, in any state, is discarded and clears stale.
  - This requires an in-order memory. While stale=1, WAIT does not forward that response.
- Latency:
  - Request accepted at cycle N; mem_req_valid_o is high at N+1.
  - Response is forwarded in the same cycle it arrives.
  - Minimum 3 cycles per transaction (IDLE, REQ, WAIT); no back-to-back accept in WAIT.
- Rules:
  - The non-owner rsp_valid is always 0.
  - *_req_ready_o is only ever 1 in IDLE.
  - mem_rsp_valid_i arriving in IDLE or REQ with stale=0 is a protocol error: ignore it and flag it via a simulation assertion.
  - The counter saturates and never wraps.

Decomposition:
- Package arb_pkg:
  - State enum {IDLE, REQ, WAIT}.
  - Owner encoding OWN_IF=0, OWN_LS=1.
  - Default TIMEOUT.
- Sub-module rr_arb2: 2-way round-robin grant from {req[1:0], last_grant} to one-hot grant; combinational, instantiated once.

Test Plan:
- IF read only, addr=0x80000000, mem ready immediately, rsp data=0x00100073 one cycle later → if_req_ready_o=1 at N, mem_req_valid_o at N+1, if_rsp_valid_o pulse with data 0x00100073, ls_rsp_valid_o stays 0.
- IF and LS both valid from reset, continuously → grants alternate IF, LS, IF, LS; a LS store (addr 0x80001000, wdata 0xDEADBEEF, mask 0x0F) appears on mem_* unchanged.
- mem_req_ready_i held low 10 cycles → mem_req_valid_o and fields stable for all 10 cycles; no timeout error.
- TIMEOUT=8, mem never responds → owner rsp_valid with err=1 and data=0 exactly 8 cycles after entering WAIT; next request accepted; the late response is dropped, stale clears, and the following response routes correctly.
- Reset asserted in WAIT → all outputs 0 immediately, state IDLE; a response after reset release produces no rsp_valid.
- mem_rsp_err_i=1 on a LS load → ls_rsp_err_o=1 in the same cycle; arbiter returns to IDLE.
